dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin data memory arbiter with
// a two-state (IDLE/BUSY) transaction FSM and registered handshakes.
//
// Parameters:
//   DATA_WIDTH      width of address, write data and read data (32)
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   reqN, weN       requester N request (held until gntN) and write flag
//   addrN, wdataN   requester N address and store data
//   maskmodeN,sextN requester N access size and load sign extension
//   gntN            one-cycle registered grant (the BUSY cycle)
//   doneN, rdataN   one-cycle completion pulse and captured load data
//   mem_*           data memory strobes, buses and combinational result
//   conflict_count, grant_count0, grant_count1
//                   statistics, built only with DMEM_ARB_STATS_EN
//                   (tied to 0 otherwise)
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [1:0]            maskmode0,
  input  logic                  sext0,
  output logic                  gnt0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [1:0]            maskmode1,
  input  logic                  sext1,
  output logic                  gnt1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [31:0]           conflict_count,
  output logic [31:0]           grant_count0,
  output logic [31:0]           grant_count1
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            mask_q, mask_d;
  logic                  sext_q, sext_d;

  // On a tie the requester not granted last wins; a lone requester
  // always wins. last_q resets to 1 so requester 0 leads after reset.
  logic win;
  logic win_we;
  assign win    = (req0 & req1) ? ~last_q : req1;
  assign win_we = win ? we1 : we0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    sext_d      = sext_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d     = BUSY;
          owner_d     = win;
          last_d      = win;
          we_d        = win_we;
          addr_d      = win ? addr1 : addr0;
          wdata_d     = win ? wdata1 : wdata0;
          mask_d      = win ? maskmode1 : maskmode0;
          sext_d      = win ? sext1 : sext0;
          gnt0_d      = ~win;
          gnt1_d      = win;
          mem_read_d  = ~win_we;
          mem_write_d = win_we;
        end
      end
      BUSY: begin
        // Requests are ignored here; they are sampled again in the
        // IDLE cycle that carries the done pulse.
        state_d = IDLE;
        done0_d = ~owner_q;
        done1_d = owner_q;
        if (!we_q) begin
          if (owner_q) rdata1_d = mem_read_data;
          else         rdata0_d = mem_read_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      sext_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      sext_q      <= sext_d;
    end
  end

  assign gnt0           = gnt0_q;
  assign gnt1           = gnt1_q;
  assign done0          = done0_q;
  assign done1          = done1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_maskmode   = mask_q;
  assign mem_sext       = sext_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_q, conflict_d;
  logic [31:0] gcnt0_q, gcnt0_d;
  logic [31:0] gcnt1_q, gcnt1_d;
  logic        idle_edge;

  assign idle_edge = (state_q == IDLE);

  always_comb begin
    conflict_d = conflict_q;
    gcnt0_d    = gcnt0_q;
    gcnt1_d    = gcnt1_q;
    if (idle_edge && req0 && req1) conflict_d = conflict_q + 32'd1;
    if (gnt0_d) gcnt0_d = gcnt0_q + 32'd1;
    if (gnt1_d) gcnt1_d = gcnt1_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
      gcnt0_q    <= '0;
      gcnt1_q    <= '0;
    end else begin
      conflict_q <= conflict_d;
      gcnt0_q    <= gcnt0_d;
      gcnt1_q    <= gcnt1_d;
    end
  end

  assign conflict_count = conflict_q;
  assign grant_count0   = gcnt0_q;
  assign grant_count1   = gcnt1_q;
`else
  assign conflict_count = '0;
  assign grant_count0   = '0;
  assign grant_count1   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: read, write,
// back-to-back, round-robin contention and reset mid-transaction.
module tb_dmem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, sext0 = 1'b0;
  logic          req1 = 1'b0, we1 = 1'b0, sext1 = 1'b0;
  logic [DW-1:0] addr0 = '0, wdata0 = '0;
  logic [DW-1:0] addr1 = '0, wdata1 = '0;
  logic [1:0]    maskmode0 = 2'd0, maskmode1 = 2'd0;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_read, mem_write, mem_sext;
  logic [DW-1:0] mem_address, mem_write_data;
  logic [DW-1:0] mem_read_data = '0;
  logic [1:0]    mem_maskmode;
  logic [31:0]   conflict_count, grant_count0, grant_count1;

  int checks = 0;
  int errors = 0;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [31:0] EXP_CONF = 32'd2;
  localparam logic [31:0] EXP_GC   = 32'd2;
`else
  localparam logic [31:0] EXP_CONF = 32'd0;
  localparam logic [31:0] EXP_GC   = 32'd0;
`endif

  dmem_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .maskmode0      (maskmode0),
    .sext0          (sext0),
    .gnt0           (gnt0),
    .done0          (done0),
    .rdata0         (rdata0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .maskmode1      (maskmode1),
    .sext1          (sext1),
    .gnt1           (gnt1),
    .done1          (done1),
    .rdata1         (rdata1),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_maskmode   (mem_maskmode),
    .mem_sext       (mem_sext),
    .mem_read_data  (mem_read_data),
    .conflict_count (conflict_count),
    .grant_count0   (grant_count0),
    .grant_count1   (grant_count1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    step();
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_done", {30'd0, done0, done1}, 32'd0);
    chk("rst_memrw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_conf", conflict_count, 32'd0);
    chk("rst_gc0", grant_count0, 32'd0);
    rst = 1'b0;
    step();

    // single read from requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    mem_read_data = 32'hDEADBEEF;
    step();
    chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rd_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rd_mrd", {31'd0, mem_read}, 32'd1);
    chk("rd_mwr", {31'd0, mem_write}, 32'd0);
    chk("rd_addr", mem_address, 32'h10);
    req0 = 1'b0;
    step();
    chk("rd_done0", {31'd0, done0}, 32'd1);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    chk("rd_idle_mrd", {31'd0, mem_read}, 32'd0);
    chk("rd_addr_hold", mem_address, 32'h10);
    step();
    chk("rd_done0_end", {31'd0, done0}, 32'd0);

    // single write from requester 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20;
    wdata1 = 32'h12345678; maskmode1 = 2'd2;
    mem_read_data = 32'hCAFEF00D;
    step();
    chk("wr_gnt1", {31'd0, gnt1}, 32'd1);
    chk("wr_gnt0", {31'd0, gnt0}, 32'd0);
    chk("wr_mwr", {31'd0, mem_write}, 32'd1);
    chk("wr_mrd", {31'd0, mem_read}, 32'd0);
    chk("wr_addr", mem_address, 32'h20);
    chk("wr_wdata", mem_write_data, 32'h12345678);
    chk("wr_mask", {30'd0, mem_maskmode}, 32'd2);
    req1 = 1'b0;
    step();
    chk("wr_mwr_drop", {31'd0, mem_write}, 32'd0);
    chk("wr_done1", {31'd0, done1}, 32'd1);
    chk("wr_done0", {31'd0, done0}, 32'd0);
    chk("wr_rdata1", rdata1, 32'd0);
    step();
    chk("wr_done1_end", {31'd0, done1}, 32'd0);

    // back-to-back reads from requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h44;
    step();
    chk("bb_gnt0_a", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    step();
    chk("bb_done0", {31'd0, done0}, 32'd1);
    chk("bb_gnt0_gap", {31'd0, gnt0}, 32'd0);
    req0 = 1'b1; addr0 = 32'h48;
    step();
    chk("bb_gnt0_b", {31'd0, gnt0}, 32'd1);
    chk("bb_addr_b", mem_address, 32'h48);
    req0 = 1'b0;
    step();
    step();

    // contention from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200;
    step();
    chk("ct_g1_gnt0", {31'd0, gnt0}, 32'd1);
    chk("ct_g1_gnt1", {31'd0, gnt1}, 32'd0);
    req0 = 1'b0;
    step();
    chk("ct_done0", {31'd0, done0}, 32'd1);
    chk("ct_nognt", {30'd0, gnt0, gnt1}, 32'd0);
    step();
    chk("ct_g2_gnt1", {31'd0, gnt1}, 32'd1);
    chk("ct_g2_gnt0", {31'd0, gnt0}, 32'd0);
    chk("ct_g2_addr", mem_address, 32'h200);
    req0 = 1'b1;
    step();
    chk("ct_done1", {30'd0, done0, done1}, 32'd1);
    step();
    chk("ct_g3_gnt0", {31'd0, gnt0}, 32'd1);
    chk("ct_g3_gnt1", {31'd0, gnt1}, 32'd0);
    req0 = 1'b0;
    step();
    step();
    chk("ct_g4_gnt1", {31'd0, gnt1}, 32'd1);
    chk("ct_g4_gnt0", {31'd0, gnt0}, 32'd0);
    chk("ct_conf", conflict_count, EXP_CONF);
    chk("ct_gc0", grant_count0, EXP_GC);
    chk("ct_gc1", grant_count1, EXP_GC);
    req1 = 1'b0;
    step();
    step();

    // reset during a write BUSY cycle
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h300; wdata1 = 32'hA5A5A5A5;
    step();
    chk("rb_mwr", {31'd0, mem_write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rb_mwr_drop", {31'd0, mem_write}, 32'd0);
    chk("rb_gnt1_drop", {31'd0, gnt1}, 32'd0);
    req1 = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rb_no_done", {30'd0, done0, done1}, 32'd0);
    chk("rb_no_mwr", {31'd0, mem_write}, 32'd0);
    chk("rb_addr0", mem_address, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h400;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h500;
    step();
    chk("rb_prio_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rb_prio_gnt1", {31'd0, gnt1}, 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
